relu_pool_l1: RTL and testbench
===============================

// Module: relu_pool_l1
// PURPOSE
//  Post-processing stage directly downstream of the layer-1 three-channel conv sum.
//  Takes the signed 16-bit summed conv stream, adds a per-layer bias and applies ReLU.
//  Requantizes the result to 8 bits (right shift, saturate), then does 2x2 stride-2 max-pooling.
//  Emits an 8-bit pooled pixel stream that feeds the layer-2 input.
// PARAMETERS
//  IMG_W   30  conv-output row width in pixels; must be even and >= 2
//  IMG_H   30  conv-output rows per frame; must be even and >= 2
//  SHIFT   4   requantization right-shift, 0..15
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   synchronous, active-high reset
//  pxl_in     in   16  conv sum, two's-complement signed, row-major raster order
//  valid_in   in   1   pxl_in valid this cycle; gaps are allowed; no backpressure
//  bias       in   16  signed bias; held stable for the whole frame
//  pxl_out    out  8   pooled, quantized pixel
//  valid_out  out  1   single-cycle strobe qualifying pxl_out
//  frame_done out  1   single-cycle pulse, coincident with the last valid_out of a frame
// BEHAVIOUR
//  Reset values: pxl_out=0, valid_out=0, frame_done=0, col=0, row=0, all pipeline valids=0.
//  Line-buffer contents are not reset; they are don't-care.
//  Stage 1 (relu_quant), registered:
//   - s = sext17(pxl_in) + sext17(bias)
//   - r = (s<0) ? 0 : s>>>SHIFT
//   - q = (r>255) ? 255 : r[7:0]
//   - v1 <= valid_in
//  Counters: col counts 0..IMG_W-1 and row counts 0..IMG_H-1, advancing only on v1.
//   - col wraps to 0 and row increments; at col=IMG_W-1 and row=IMG_H-1 both wrap to 0.
//  Stage 2 (pool), on v1:
//   - even col: hold <= q
//   - odd col, even row: lbuf[col>>1] <= max(hold,q); no output
//   - odd col, odd row: pxl_out <= max(lbuf[col>>1],hold,q); valid_out <= 1
//  Latency: valid_out rises 2 clk after the valid_in carrying the bottom-right pixel of the 2x2 window.
//  Outputs per frame: (IMG_W/2)*(IMG_H/2).
//  frame_done <= 1 together with the valid_out for row=IMG_H-1, col=IMG_W-1.
//  Gaps in valid_in stall the counters and pool state only; no state is lost.
//  valid_out and frame_done are 0 on every cycle not described above.
//  Reset mid-frame: counters and valids clear on the reset cycle, and in-flight stage-1 data is dropped.
//   - the next accepted pixel is treated as (row0,col0)
//   - no partial-window output is ever emitted
//  Back-to-back frames: the first pixel of frame N+1 may arrive the cycle after the last pixel of frame N.
//  Line buffer: IMG_W/2 x 8 bits, one write and one read per cycle; register/distributed RAM only, no BRAM latency.
//  Width/parameter violation: elaboration-time check (generate-time $error on odd IMG_W/IMG_H).
// STRUCTURE
//  cnn_defs.vh (shared include):
//   - CONV_W=16, PXL_W=8, BIAS_W=16
//   - image-size defines for layers 1/2
//  Sub-module relu_quant: bias add, ReLU, shift and saturate; one register stage; parameter SHIFT.
//  Top contains the counters, hold register, line buffer, max comparators and output registers.
// TESTING
//  1 Assert reset 3 cycles with random inputs -> pxl_out=0, valid_out=0, frame_done=0 throughout.
//  2 IMG_W=4, IMG_H=4, SHIFT=0, bias=0, pxl_in=0..15 continuous:
//    -> pxl_out 5,7,13,15, each 2 clk after inputs 5,7,13,15; frame_done with the 15.
//  3 SHIFT=0, all pxl_in=16'hFF00 (-256):
//    -> bias=0 gives all outputs 0; bias=300 gives all outputs 44.
//  4 SHIFT=4, bias=0, pxl_in=16'h7FFF -> 255 (saturated); pxl_in=16'h0FF0 -> 255; pxl_in=16'h00A0 -> 10.
//  5 Test 2 stimulus with random valid_in gaps (~40% idle) -> identical output sequence and frame_done.
//  6 Test 2 stimulus, then reset after 5 pixels, then a full frame of pxl_in=0..15:
//    -> exactly 4 outputs (5,7,13,15), one frame_done.
//  7 Two back-to-back frames with no idle cycles, default params and random data:
//    -> 225 outputs per frame matching the reference model; 2 frame_done pulses.

Source files
------------

// File: rtl/relu_pool_l1_pkg.sv
// relu_pool_l1_pkg: shared widths, layer-1 geometry and the pixel max helper
package relu_pool_l1_pkg;
    localparam int CONV_W    = 16;
    localparam int PXL_W     = 8;
    localparam int BIAS_W    = 16;
    localparam int L1_W      = 30;
    localparam int L1_H      = 30;
    localparam int DEF_SHIFT = 4;

    function automatic logic [PXL_W-1:0] max_pxl(input logic [PXL_W-1:0] a, input logic [PXL_W-1:0] b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/relu_quant.sv
// relu_quant: bias add, ReLU, requantize by right shift and saturate to 8 bits; one register stage
module relu_quant
    import relu_pool_l1_pkg::*;
#(
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CONV_W-1:0] pxl_in,
    input  logic              valid_in,
    input  logic [BIAS_W-1:0] bias,
    output logic [PXL_W-1:0]  q,
    output logic              valid
);
    logic signed [CONV_W:0] s;
    logic [CONV_W:0] r;
    logic [PXL_W-1:0] sat;

    // one guard bit keeps the signed sum exact
    always_comb begin
        s = $signed({pxl_in[CONV_W-1], pxl_in}) + $signed({bias[BIAS_W-1], bias});
        r = s[CONV_W] ? '0 : (CONV_W+1)'(s >>> SHIFT);
        sat = (r > (CONV_W+1)'(255)) ? '1 : r[PXL_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) valid <= 1'b0;
        else valid <= valid_in;
        q <= sat;
    end
endmodule

// File: rtl/relu_pool_l1.sv
// relu_pool_l1: bias+ReLU+requantize followed by 2x2 stride-2 max-pooling of the layer-1 conv stream
module relu_pool_l1
    import relu_pool_l1_pkg::*;
#(
    parameter int IMG_W = L1_W,
    parameter int IMG_H = L1_H,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CONV_W-1:0] pxl_in,
    input  logic              valid_in,
    input  logic [BIAS_W-1:0] bias,
    output logic [PXL_W-1:0]  pxl_out,
    output logic              valid_out,
    output logic              frame_done
);
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int HALF = IMG_W / 2;
    localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

    if ((IMG_W % 2) != 0 || IMG_W < 2 || (IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_size
        $error("relu_pool_l1: IMG_W and IMG_H must be even and >= 2");
    end

    logic [PXL_W-1:0] q, hold, top_max, win_max;
    logic [PXL_W-1:0] lbuf [HALF];
    logic             v1, last_col, last_row;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [AW-1:0]    addr;

    relu_quant #(.SHIFT(SHIFT)) u_relu_quant (
        .clk      (clk),
        .reset    (reset),
        .pxl_in   (pxl_in),
        .valid_in (valid_in),
        .bias     (bias),
        .q        (q),
        .valid    (v1)
    );

    always_comb begin
        last_col = col == CW'(IMG_W - 1);
        last_row = row == RW'(IMG_H - 1);
        addr = AW'(col >> 1);
        top_max = max_pxl(hold, q);
        win_max = max_pxl(lbuf[addr], top_max);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
            pxl_out <= '0;
            valid_out <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            frame_done <= 1'b0;
            if (v1) begin
                col <= last_col ? '0 : col + 1'b1;
                row <= last_col ? (last_row ? '0 : row + 1'b1) : row;
                if (col[0] && row[0]) begin
                    pxl_out <= win_max;
                    valid_out <= 1'b1;
                    frame_done <= last_col && last_row;
                end
            end
        end
    end

    // even rows park the top-pair max in the line buffer until the odd row closes the window
    always_ff @(posedge clk) begin
        if (v1) begin
            if (!col[0]) hold <= q;
            else if (!row[0]) lbuf[addr] <= top_max;
        end
    end
endmodule

// File: tb/tb_relu_pool_l1.sv
// tb_relu_pool_l1: randomized checks of two relu_pool_l1 instances (4x4/SHIFT0 and 30x30/SHIFT4) against a frame-array model
module tb_relu_pool_l1;
    localparam int WA = 4, HA = 4, SA = 0;
    localparam int WB = 30, HB = 30, SB = 4;

    typedef struct {
        int pix;
        int fd;
        int cyc;
    } exp_t;

    logic clk = 1'b0, reset = 1'b1;
    logic [15:0] pin_a = '0, pin_b = '0, bias = '0;
    logic vin_a = 1'b0, vin_b = 1'b0;
    logic [7:0] po_a, po_b;
    logic vo_a, vo_b, fd_a, fd_b;

    int cyc = 0;
    int n_cmp = 0, n_bad = 0;
    int nfd [2] = '{0, 0};
    int pr [2] = '{0, 0};
    int pc [2] = '{0, 0};
    int qv [2][30][30];
    exp_t eq_a[$], eq_b[$];
    int obs_a[$], obs_b[$];

    relu_pool_l1 #(.IMG_W(WA), .IMG_H(HA), .SHIFT(SA)) dut_a (
        .clk(clk), .reset(reset), .pxl_in(pin_a), .valid_in(vin_a), .bias(bias),
        .pxl_out(po_a), .valid_out(vo_a), .frame_done(fd_a)
    );

    relu_pool_l1 #(.IMG_W(WB), .IMG_H(HB), .SHIFT(SB)) dut_b (
        .clk(clk), .reset(reset), .pxl_in(pin_b), .valid_in(vin_b), .bias(bias),
        .pxl_out(po_b), .valid_out(vo_b), .frame_done(fd_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int quant(input int d, input logic [15:0] p, input logic [15:0] b);
        int s = int'($signed(p)) + int'($signed(b));
        if (s < 0) return 0;
        s = s / (2 ** (d ? SB : SA));
        return (s > 255) ? 255 : s;
    endfunction

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // the model stores the whole quantized frame and pools straight from it
    task automatic model_push(input int d, input logic [15:0] p, input logic [15:0] b);
        int r = pr[d], c = pc[d];
        int w = d ? WB : WA, h = d ? HB : HA;
        exp_t e;
        qv[d][r][c] = quant(d, p, b);
        if (r % 2 == 1 && c % 2 == 1) begin
            e.pix = mx(mx(qv[d][r-1][c-1], qv[d][r-1][c]), mx(qv[d][r][c-1], qv[d][r][c]));
            e.fd = (r == h - 1 && c == w - 1) ? 1 : 0;
            e.cyc = cyc + 2;
            if (d == 0) eq_a.push_back(e);
            else eq_b.push_back(e);
        end
        c++;
        if (c == w) begin
            c = 0;
            r = (r == h - 1) ? 0 : r + 1;
        end
        pr[d] = r;
        pc[d] = c;
    endtask

    task automatic drive(input int d, input logic [15:0] p, input logic v, input logic [15:0] b);
        @(posedge clk);
        #1;
        bias = b;
        if (d == 0) begin
            pin_a = p;
            vin_a = v;
        end else begin
            pin_b = p;
            vin_b = v;
        end
        if (v) model_push(d, p, b);
    endtask

    task automatic observe(input int d, input logic [7:0] po, input logic vo, input logic fd);
        exp_t e;
        int avail;
        if (fd === 1'b1) check(d ? "b_fd_without_valid" : "a_fd_without_valid", {31'b0, vo}, 1);
        if (vo === 1'b1) begin
            if (fd === 1'b1) nfd[d]++;
            if (d == 0) obs_a.push_back(int'(po));
            else obs_b.push_back(int'(po));
            avail = (d == 0) ? eq_a.size() : eq_b.size();
            check(d ? "b_output_expected" : "a_output_expected", 32'(avail > 0), 1);
            if (avail > 0) begin
                if (d == 0) e = eq_a.pop_front();
                else e = eq_b.pop_front();
                check(d ? "b_pixel" : "a_pixel", {24'b0, po}, e.pix);
                check(d ? "b_frame_done" : "a_frame_done", {31'b0, fd}, e.fd);
                check(d ? "b_latency" : "a_latency", cyc, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        observe(0, po_a, vo_a, fd_a);
        observe(1, po_b, vo_b, fd_b);
    end

    task automatic flush(input int d, input logic [15:0] b);
        repeat (4) drive(d, 16'h0, 1'b0, b);
        check(d ? "b_drained" : "a_drained", (d == 0) ? eq_a.size() : eq_b.size(), 0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (n) begin
            pin_a = 16'($urandom);
            vin_a = 1'($urandom);
            pin_b = 16'($urandom);
            vin_b = 1'($urandom);
            bias = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("a_rst_pxl_out", {24'b0, po_a}, 0);
            check("a_rst_valid_out", {31'b0, vo_a}, 0);
            check("a_rst_frame_done", {31'b0, fd_a}, 0);
            check("b_rst_pxl_out", {24'b0, po_b}, 0);
            check("b_rst_valid_out", {31'b0, vo_b}, 0);
            check("b_rst_frame_done", {31'b0, fd_b}, 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        vin_a = 1'b0;
        vin_b = 1'b0;
        pr = '{0, 0};
        pc = '{0, 0};
        eq_a.delete();
        eq_b.delete();
    endtask

    task automatic check_a4(input string tag, input int f0);
        int exp4 [4] = '{5, 7, 13, 15};
        check({tag, "_count"}, obs_a.size(), 4);
        for (int i = 0; i < 4; i++) check({tag, "_value"}, (i < obs_a.size()) ? obs_a[i] : -1, exp4[i]);
        check({tag, "_frames"}, nfd[0] - f0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int f0;
        int vals [3] = '{32'h7FFF, 32'h0FF0, 32'h00A0};
        int outs [3] = '{255, 255, 10};
        logic [15:0] rb;

        do_reset(3);

        obs_a.delete();
        f0 = nfd[0];
        for (int i = 0; i < 16; i++) drive(0, 16'(i), 1'b1, 16'h0);
        flush(0, 16'h0);
        check_a4("ramp", f0);

        obs_a.delete();
        f0 = nfd[0];
        repeat (16) drive(0, 16'hFF00, 1'b1, 16'h0);
        repeat (16) drive(0, 16'hFF00, 1'b1, 16'd300);
        flush(0, 16'd300);
        check("neg_count", obs_a.size(), 8);
        for (int i = 0; i < 8; i++) check("neg_value", (i < obs_a.size()) ? obs_a[i] : -1, (i < 4) ? 0 : 44);
        check("neg_frames", nfd[0] - f0, 2);

        for (int k = 0; k < 3; k++) begin
            obs_b.delete();
            f0 = nfd[1];
            repeat (WB * HB) drive(1, 16'(vals[k]), 1'b1, 16'h0);
            flush(1, 16'h0);
            check("sat_count", obs_b.size(), 225);
            check("sat_first", (obs_b.size() > 0) ? obs_b[0] : -1, outs[k]);
            check("sat_last", (obs_b.size() > 224) ? obs_b[224] : -1, outs[k]);
            check("sat_frames", nfd[1] - f0, 1);
        end

        obs_a.delete();
        f0 = nfd[0];
        for (int i = 0; i < 16; i++) begin
            while ($urandom_range(0, 99) < 40) drive(0, 16'($urandom), 1'b0, 16'h0);
            drive(0, 16'(i), 1'b1, 16'h0);
        end
        flush(0, 16'h0);
        check_a4("gaps", f0);

        obs_a.delete();
        for (int i = 0; i < 5; i++) drive(0, 16'(i), 1'b1, 16'h0);
        do_reset(1);
        f0 = nfd[0];
        for (int i = 0; i < 16; i++) drive(0, 16'(i), 1'b1, 16'h0);
        flush(0, 16'h0);
        check_a4("midreset", f0);

        obs_b.delete();
        f0 = nfd[1];
        rb = 16'(int'($urandom_range(0, 400)) - 200);
        repeat (2 * WB * HB) drive(1, 16'(int'($urandom_range(0, 8000)) - 3000), 1'b1, rb);
        flush(1, rb);
        check("b2b_count", obs_b.size(), 450);
        check("b2b_frames", nfd[1] - f0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
